// File: rtl/ps2_keymap_pkg.sv
// Shared definitions for the PS/2 key mapper: scan-code constants, parser
// state encoding, default key table and the parser-to-mapper event record.
package ps2_keymap_pkg;

  localparam logic [7:0] SC_EXT          = 8'hE0;
  localparam logic [7:0] SC_BRK          = 8'hF0;
  localparam logic [7:0] SC_FAKE_SHIFT_L = 8'h12;
  localparam logic [7:0] SC_FAKE_SHIFT_R = 8'h59;

  localparam int DEFAULT_NUM_KEYS = 10;

  // Entry i sits at bits [9*i +: 9], so the last listed code is key 0 (A_up).
  localparam logic [9*DEFAULT_NUM_KEYS-1:0] DEFAULT_KEY_CODES = {
    9'h070, 9'h06B, 9'h072, 9'h074, 9'h075,
    9'h029, 9'h01C, 9'h01B, 9'h023, 9'h01D
  };

  localparam logic [DEFAULT_NUM_KEYS-1:0] DEFAULT_REPEAT_MASK = 10'b10_0001_0000;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_EXT,
    ST_BRK,
    ST_EXT_BRK
  } parser_state_t;

  typedef struct packed {
    logic       valid;
    logic       is_break;
    logic [8:0] code;
  } key_event_t;

  // Keyboard status/ack bytes that carry no key information.
  function automatic logic is_ignored(input logic [7:0] b);
    case (b)
      8'hE1, 8'hAA, 8'hFA, 8'hFE, 8'hEE, 8'h00, 8'hFF: return 1'b1;
      default:                                        return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/ps2_scan_parser.sv
// Scan-code sequence parser: turns the PS/2 byte stream into one-cycle
// make/break events and abandons sequences left hanging for TIMEOUT cycles.
module ps2_scan_parser
  import ps2_keymap_pkg::*;
#(
  parameter int TIMEOUT = 1_000_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] rx_data,
  input  logic       rx_valid,
  output key_event_t evt,
  output logic       seq_error
);

  localparam int TW = $clog2(TIMEOUT);
  localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT - 1);

  parser_state_t state, state_nx;
  logic [TW-1:0] tcnt, tcnt_nx;
  key_event_t    evt_nx;
  logic          err_nx;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= ST_IDLE;
      tcnt      <= '0;
      evt       <= '0;
      seq_error <= 1'b0;
    end else begin
      state     <= state_nx;
      tcnt      <= tcnt_nx;
      evt       <= evt_nx;
      seq_error <= err_nx;
    end
  end

  // A received byte always wins over a timeout expiring in the same cycle.
  always_comb begin
    state_nx = state;
    tcnt_nx  = '0;
    evt_nx   = '0;
    err_nx   = 1'b0;
    if (rx_valid) begin
      case (state)
        ST_IDLE: begin
          if (rx_data == SC_EXT) begin
            state_nx = ST_EXT;
          end else if (rx_data == SC_BRK) begin
            state_nx = ST_BRK;
          end else if (!is_ignored(rx_data)) begin
            evt_nx.valid = 1'b1;
            evt_nx.code  = {1'b0, rx_data};
          end
        end
        ST_EXT: begin
          if (rx_data == SC_BRK) begin
            state_nx = ST_EXT_BRK;
          end else begin
            state_nx = ST_IDLE;
            if (rx_data != SC_FAKE_SHIFT_L && rx_data != SC_FAKE_SHIFT_R) begin
              evt_nx.valid = 1'b1;
              evt_nx.code  = {1'b1, rx_data};
            end
          end
        end
        ST_BRK: begin
          state_nx        = ST_IDLE;
          evt_nx.valid    = 1'b1;
          evt_nx.is_break = 1'b1;
          evt_nx.code     = {1'b0, rx_data};
        end
        ST_EXT_BRK: begin
          state_nx        = ST_IDLE;
          evt_nx.valid    = 1'b1;
          evt_nx.is_break = 1'b1;
          evt_nx.code     = {1'b1, rx_data};
        end
        default: state_nx = ST_IDLE;
      endcase
    end else if (state != ST_IDLE) begin
      if (tcnt == TO_LAST) begin
        state_nx = ST_IDLE;
        err_nx   = 1'b1;
      end else begin
        tcnt_nx = tcnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/ps2_key_mapper.sv
// Maps parsed PS/2 make/break events onto NUM_KEYS held levels with press,
// release and optional auto-repeat pulses for the game control logic.
module ps2_key_mapper
  import ps2_keymap_pkg::*;
#(
  parameter int                        NUM_KEYS      = DEFAULT_NUM_KEYS,
  parameter logic [9*NUM_KEYS-1:0]     KEY_CODES     = DEFAULT_KEY_CODES,
  parameter logic [NUM_KEYS-1:0]       REPEAT_MASK   = DEFAULT_REPEAT_MASK,
  parameter int                        REPEAT_PERIOD = 5_000_000,
  parameter int                        TIMEOUT       = 1_000_000
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [7:0]          rx_data,
  input  logic                rx_valid,
  input  logic                flush,
  output logic [NUM_KEYS-1:0] key_held,
  output logic [NUM_KEYS-1:0] key_press,
  output logic [NUM_KEYS-1:0] key_release,
  output logic                seq_error
);

  localparam int RW = $clog2(REPEAT_PERIOD);
  localparam logic [RW-1:0] REP_LAST = RW'(REPEAT_PERIOD - 1);

  key_event_t evt;

  ps2_scan_parser #(
    .TIMEOUT (TIMEOUT)
  ) u_parser (
    .clk       (clk),
    .rst       (rst),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .evt       (evt),
    .seq_error (seq_error)
  );

  for (genvar i = 0; i < NUM_KEYS; i++) begin : g_key
    logic hit, make_hit, brk_hit, wrap;
    logic held_q, press_q, rel_q;

    assign hit      = evt.valid && (evt.code == KEY_CODES[9*i +: 9]);
    assign make_hit = hit && !evt.is_break;
    assign brk_hit  = hit && evt.is_break;

    if (REPEAT_MASK[i]) begin : g_rep
      logic [RW-1:0] cnt;

      // Counter idles at zero whenever the key is up, so a fresh make starts from 0.
      always_ff @(posedge clk) begin
        if (!rst || flush || !held_q || brk_hit) begin
          cnt <= '0;
        end else if (cnt == REP_LAST) begin
          cnt <= '0;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end

      assign wrap = held_q && (cnt == REP_LAST);
    end else begin : g_norep
      assign wrap = 1'b0;
    end

    // Break beats a coinciding repeat wrap; flush beats everything without a release.
    always_ff @(posedge clk) begin
      if (!rst) begin
        held_q  <= 1'b0;
        press_q <= 1'b0;
        rel_q   <= 1'b0;
      end else begin
        press_q <= 1'b0;
        rel_q   <= 1'b0;
        if (flush) begin
          held_q <= 1'b0;
        end else if (held_q) begin
          if (brk_hit) begin
            held_q <= 1'b0;
            rel_q  <= 1'b1;
          end else if (wrap) begin
            press_q <= 1'b1;
          end
        end else if (make_hit) begin
          held_q  <= 1'b1;
          press_q <= 1'b1;
        end
      end
    end

    assign key_held[i]    = held_q;
    assign key_press[i]   = press_q;
    assign key_release[i] = rel_q;
  end

endmodule

// File: doc/ps2_key_mapper.md
Name: ps2_key_mapper

Overview:
- Parametrised successor to the per-player key decoder in the plane game.
- Consumes the byte stream from the PS/2 receiver and parses make, break and extended (E0) scan-code sequences with a proper state machine.
- Maps NUM_KEYS configurable 9-bit codes to independent held levels, press pulses and release pulses.
- Supports optional per-key auto-repeat, for example held-fire, and sits between the PS/2 receiver and the game/VGA control logic.

Parameters:
- NUM_KEYS, 10, number of mapped keys.
- KEY_CODES, {9'h070,9'h06B,9'h072,9'h074,9'h075,9'h029,9'h01C,9'h01B,9'h023,9'h01D}, packed table; entry i = KEY_CODES[9*i+:9] = {ext, code}. Default index order: 0 A_up, 1 A_right, 2 A_down, 3 A_left, 4 A_fire, 5 B_up, 6 B_right, 7 B_down, 8 B_left, 9 B_fire.
- REPEAT_MASK, 10'b10_0001_0000, bit i set enables auto-repeat on key i (fire keys by default).
- REPEAT_PERIOD, 5_000_000, cycles between repeated press pulses while held; must be ≥2.
- TIMEOUT, 1_000_000, idle cycles after which a partial sequence is abandoned.

Ports:
- clk, in, 1, system clock.
- rst, in, 1, synchronous active-low reset.
- rx_data, in, 8, received scan-code byte.
- rx_valid, in, 1, one-cycle strobe; rx_data is valid.
- flush, in, 1, clears all held state (game restart).
- key_held, out, NUM_KEYS, level: key currently down.
- key_press, out, NUM_KEYS, one-cycle pulse on make edge and on each auto-repeat.
- key_release, out, NUM_KEYS, one-cycle pulse on break of a held key.
- seq_error, out, 1, one-cycle pulse when a partial sequence times out.

Behaviour:
- Reset:
  - rst sampled low at a clk edge → parser enters IDLE.
  - key_held, key_press, key_release and seq_error become 0; all repeat and timeout counters are cleared.
  - Reset mid-sequence discards the partial sequence.
- Parser FSM states: IDLE, EXT, BRK, EXT_BRK.
  - IDLE: E0→EXT; F0→BRK; E1, AA, FA, FE, EE, 00 and FF are ignored (stay in IDLE); any other byte c → make {0,c}.
  - EXT: F0→EXT_BRK; 12/59 (fake shift) → IDLE, ignored; other c → make {1,c}, →IDLE.
  - BRK: c → break {0,c}, →IDLE.
  - EXT_BRK: c → break {1,c}, →IDLE.
  - Transitions occur only on rx_valid cycles.
- Timeout counter:
  - Resets on every rx_valid and runs only in a non-IDLE state.
  - On reaching TIMEOUT−1 the FSM returns to IDLE and seq_error pulses.
  - rx_valid arriving in the same cycle as expiry takes priority: the byte is processed and there is no error.
- Key match: a make or break event is compared against all NUM_KEYS entries in parallel. Duplicate table entries are all updated. Unmatched codes have no effect.
- Latency: the byte that completes a sequence, accepted at edge t, produces key_held, key_press and key_release changes at edge t+1. All outputs are registered.
- Make on key i:
  - If not held: key_held[i]←1 and key_press[i] pulses; the repeat counter for i is loaded with 0.
  - If already held (typematic repeat from the keyboard): no pulse, no counter change.
- Break on key i:
  - If held: key_held[i]←0 and key_release[i] pulses.
  - If not held: no effect.
- Keys are independent: one event never blocks the update of another key. There is no priority chain.
- Auto-repeat (REPEAT_MASK[i]=1): while held, counter i increments each cycle. At REPEAT_PERIOD−1 it wraps to 0 and key_press[i] pulses. Break stops the counter and clears it to 0.
- flush:
  - Clears key_held and all repeat counters at the next edge; no release pulses are generated.
  - Parser state is preserved.
  - flush has priority over a same-cycle make, so that key is not held afterwards.
- Simultaneous auto-repeat wrap on key i and break on key i: the break wins, key_release pulses, key_press does not.

Decomposition:
- Package ps2_keymap_pkg holds:
  - scan-code constants: E0, F0 and the ignore set;
  - the parser state encoding;
  - default key-code constants;
  - the event record {valid, is_break, code[8:0]}.
- Sub-module ps2_scan_parser contains the FSM and the timeout counter, and emits a one-cycle event record.
- The top level instantiates the parser plus per-key held/repeat logic in a generate loop.

Test Plan:
- Reset low for 2 cycles, then stream 1D → at t+1, key_held=10'b0000000001 and key_press[0] pulses for 1 cycle; then stream F0,1D → key_held=0 and key_release[0] pulses.
- Stream E0,75 → no output change (the extended up arrow is not mapped); stream 75 → key_held[5]=1 and key_press[5] pulses.
- Stream 1D, 1D, 1D (typematic) → exactly one key_press[0] pulse.
- Stream 29 with REPEAT_PERIOD=8 and hold → key_press[4] pulses at t+1, t+9, t+17…; stream F0,29 → pulses stop and one key_release[4] pulse.
- Stream F0 then idle TIMEOUT cycles (TIMEOUT=16) → seq_error pulses once; then stream 1C → key_held[3]=1 (treated as a make, not a break).
- Hold keys 0 and 5, assert flush for 1 cycle → key_held=0 with no key_release pulses; assert rst low while in BRK state, then stream 1D → key_held[0]=1.
